// File: rtl/key_expansion_seq.sv
// key_expansion_seq: sequential AES-128/192/256 key schedule, one word per clock, full schedule kept for indexed reads.
// Define KEYEXP_REGREAD_EN to register the round_key read port (one cycle read latency).
//
// state  | meaning
// IDLE   | waiting for start; stored schedule readable while keys_valid
// EXPAND | generating w[i], one word per cycle, busy high
// DONE   | one-cycle completion pulse; keys_valid set on exit
module key_expansion_seq #(
  parameter int MAX_NK = 8,
  parameter int IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           key_len,
  input  logic [32*MAX_NK-1:0] key_in,
  output logic                 busy,
  output logic                 done,
  output logic                 keys_valid,
  output logic                 err,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [127:0]         round_key
);
  localparam int MAX_NR = MAX_NK + 6;
  localparam int TOT_W  = 4 * (MAX_NR + 1);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]  w_mem [TOT_W];
  logic [5:0]   wr_idx, words_left, left_sel;
  logic [3:0]   nk, nr, nk_sel, nr_sel;
  logic [2:0]   pos;
  logic [7:0]   rcon;
  logic         start_ok, start_bad;
  logic [31:0]  prev_w, old_w, rot_w, sub_w, temp_w, new_w;
  logic [127:0] rk_sel;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    nk_sel   = 4'd0;
    nr_sel   = 4'd0;
    left_sel = 6'd0;
    case (key_len)
      2'd0:    begin nk_sel = 4'd4; nr_sel = 4'd10; left_sel = 6'd40; end
      2'd1:    begin nk_sel = 4'd6; nr_sel = 4'd12; left_sel = 6'd46; end
      2'd2:    begin nk_sel = 4'd8; nr_sel = 4'd14; left_sel = 6'd52; end
      default: begin nk_sel = 4'd0; nr_sel = 4'd0;  left_sel = 6'd0;  end
    endcase
  end

  // Key sizes wider than the instance can hold are rejected like key_len = 3.
  assign start_bad = start && (state == IDLE) && ((key_len == 2'd3) || (nk_sel > 4'(MAX_NK)));
  assign start_ok  = start && (state == IDLE) && !start_bad;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start_ok) state_nxt = EXPAND;
      EXPAND:  begin
        busy = 1'b1;
        if (words_left == 6'd1) state_nxt = DONE;
      end
      DONE:    begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single shared SubWord; RotWord only on the i%Nk == 0 step.
  always_comb begin
    prev_w = w_mem[wr_idx - 6'd1];
    old_w  = w_mem[wr_idx - {2'b00, nk}];
    rot_w  = (pos == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_w  = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
    if (pos == 3'd0)                     temp_w = sub_w ^ {rcon, 24'h0};
    else if (nk == 4'd8 && pos == 3'd4) temp_w = sub_w;
    else                                 temp_w = prev_w;
    new_w = old_w ^ temp_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keys_valid <= 1'b0;
      err        <= 1'b0;
      rcon       <= 8'h01;
      wr_idx     <= 6'd0;
      words_left <= 6'd0;
      nk         <= 4'd0;
      nr         <= 4'd0;
      pos        <= 3'd0;
    end else begin
      err <= start_bad;
      case (state)
        IDLE: if (start_ok) begin
          nk         <= nk_sel;
          nr         <= nr_sel;
          wr_idx     <= {2'b00, nk_sel};
          words_left <= left_sel;
          pos        <= 3'd0;
          rcon       <= 8'h01;
          keys_valid <= 1'b0;
        end
        EXPAND: begin
          wr_idx     <= wr_idx + 6'd1;
          words_left <= words_left - 6'd1;
          pos        <= (pos == 3'(nk - 4'd1)) ? 3'd0 : pos + 3'd1;
          if (pos == 3'd0) rcon <= xtime(rcon);
        end
        DONE:    keys_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && start_ok) begin
      for (int j = 0; j < MAX_NK; j++)
        if (4'(j) < nk_sel) w_mem[j] <= key_in[32*(MAX_NK-j)-1 -: 32];
    end else if (!rst && state == EXPAND) begin
      w_mem[wr_idx] <= new_w;
    end
  end

  always_comb begin
    rk_sel = '0;
    for (int r = 0; r <= MAX_NR; r++)
      if (keys_valid && r <= int'(nr) && rd_idx == IDX_W'(r))
        rk_sel = {w_mem[4*r], w_mem[4*r+1], w_mem[4*r+2], w_mem[4*r+3]};
  end

`ifdef KEYEXP_REGREAD_EN
  always_ff @(posedge clk) begin
    if (rst) round_key <= '0;
    else     round_key <= rk_sel;
  end
`else
  assign round_key = rk_sel;
`endif

endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq: directed FIPS-197 vectors for key_expansion_seq, including latency, err, reset and ignored-start cases.
module tb_key_expansion_seq;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key_in = '0;
  logic [3:0]   rd_idx = 4'd0;
  logic         busy, done, keys_valid, err;
  logic [127:0] round_key;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] K128     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] RK0_192  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] RK12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK1_256  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  key_expansion_seq #(.MAX_NK(8), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid), .err(err),
    .rd_idx(rd_idx), .round_key(round_key)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start edge counts as edge 1; returns once done is seen or the budget runs out.
  // restart_at > 0 pulses a competing AES-128 start while busy.
  task automatic run_expand(input logic [1:0] len, input logic [255:0] key, input int exp_edges,
                            input int restart_at, input string tag);
    int edges;
    bit seen;
    @(negedge clk);
    key_len = len;
    key_in  = key;
    start   = 1'b1;
    edges   = 0;
    seen    = 1'b0;
    while (!seen && edges < 100) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        start   = 1'b0;
        key_in  = ~key;
        key_len = 2'd3;
        check_val({tag, "_busy"}, busy, 1);
        check_val({tag, "_kv_clr"}, keys_valid, 0);
      end
      if (restart_at > 0 && edges == restart_at) begin
        start   = 1'b1;
        key_len = 2'd0;
        key_in  = {K128, 128'h0};
      end
      if (restart_at > 0 && edges == restart_at + 1) begin
        start = 1'b0;
        check_val({tag, "_no_err"}, err, 0);
      end
      if (done) seen = 1'b1;
    end
    check_val({tag, "_latency"}, edges, exp_edges);
    check_val({tag, "_busy_done"}, busy, 0);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, done, 0);
    check_val({tag, "_kv_set"}, keys_valid, 1);
  endtask

  task automatic read_rk(input logic [3:0] idx, input logic [127:0] exp, input string tag);
    @(negedge clk);
    rd_idx = idx;
`ifdef KEYEXP_REGREAD_EN
    @(negedge clk);
`else
    #1;
`endif
    check_val(tag, round_key, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_kv", keys_valid, 0);
    check_val("rst_err", err, 0);
    check_val("rst_rk", round_key, 0);
    rst = 1'b0;

    read_rk(4'd0, 128'h0, "rk_before_valid");

    run_expand(2'd0, {K128, 128'hdeadbeef0123456789abcdeffedcba98}, 41, 0, "aes128");
    read_rk(4'd0, K128, "aes128_rk0");
    read_rk(4'd1, RK1_128, "aes128_rk1");
    read_rk(4'd10, RK10_128, "aes128_rk10");
    read_rk(4'd11, 128'h0, "aes128_rk11");
    read_rk(4'd15, 128'h0, "aes128_rk15");

`ifdef KEYEXP_REGREAD_EN
    @(negedge clk);
    rd_idx = 4'd1;
    @(negedge clk);
    rd_idx = 4'd10;
    #1;
    check_val("lag_old", round_key, RK1_128);
    @(negedge clk);
    check_val("lag_new", round_key, RK10_128);
`endif

    @(negedge clk);
    key_len = 2'd3;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("err_pulse", err, 1);
    check_val("err_busy", busy, 0);
    @(negedge clk);
    check_val("err_clear", err, 0);
    check_val("err_kv_kept", keys_valid, 1);
    read_rk(4'd1, RK1_128, "err_rk1_kept");

    run_expand(2'd1, {K192, 64'hffffffff00000000}, 47, 0, "aes192");
    read_rk(4'd0, RK0_192, "aes192_rk0");
    read_rk(4'd12, RK12_192, "aes192_rk12");
    read_rk(4'd13, 128'h0, "aes192_rk13");

    run_expand(2'd2, K256, 53, 10, "aes256");
    read_rk(4'd1, RK1_256, "aes256_rk1");
    read_rk(4'd14, RK14_256, "aes256_rk14");

    rd_idx = 4'd14;
    @(negedge clk);
    key_len = 2'd2;
    key_in  = K256;
    start   = 1'b1;
    for (int e = 1; e < 20; e++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_val("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_kv", keys_valid, 0);
    check_val("mid_rst_rk", round_key, 0);

    run_expand(2'd0, {K128, 128'h0}, 41, 0, "re128");
    read_rk(4'd10, RK10_128, "re128_rk10");

    @(negedge clk);
    rst     = 1'b1;
    start   = 1'b1;
    key_len = 2'd0;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check_val("rst_wins_busy", busy, 0);
    check_val("rst_wins_kv", keys_valid, 0);
    @(negedge clk);
    check_val("rst_wins_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
